// File: rtl/ff_reg_pkg.sv
// Shared constants and helpers for the ff_reg delay line.
// Optional feature macro: FF_REG_CLR_EN (adds a synchronous clear).
package ff_reg_pkg;

    localparam int unsigned FF_REG_W_DEFAULT     = 1;
    localparam int unsigned FF_REG_DEPTH_DEFAULT = 1;

    // Widest vector the zero helper can describe; callers cast down to their own width.
    localparam int unsigned FF_REG_MAX_W = 1024;

    // Returns a vector whose low w bits are zero; cast to W bits to form a reset value.
    function automatic logic [FF_REG_MAX_W-1:0] ff_reg_zero(input int unsigned w);
        logic [FF_REG_MAX_W-1:0] z;
        z = {FF_REG_MAX_W{1'b1}};
        for (int unsigned i = 0; i < FF_REG_MAX_W; i++) begin
            if (i < w) begin
                z[i] = 1'b0;
            end
        end
        return z;
    endfunction

endpackage

// File: rtl/ff_reg_if.sv
// Data/enable bundle for ff_reg. The clr signal exists only when FF_REG_CLR_EN is defined.
interface ff_reg_if
    import ff_reg_pkg::*;
#(
    parameter int unsigned W = FF_REG_W_DEFAULT
);

    logic         en;
    logic [W-1:0] in;
    logic [W-1:0] out;
`ifdef FF_REG_CLR_EN
    logic         clr;

    modport master (output en, output in, output clr, input out);
    modport slave  (input en, input in, input clr, output out);
`else
    modport master (output en, output in, input out);
    modport slave  (input en, input in, output out);
`endif

endinterface

// File: rtl/ff_stage.sv
// One W-bit register with synchronous reset, synchronous clear and clock enable.
module ff_stage #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next value: clear beats enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = RST_VAL;
        end else if (en) begin
            q_d = d;
        end
    end

    // State register; reset has top priority over everything else.
    always_ff @(posedge clk) begin
        if (reset_) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ff_reg.sv
// DEPTH-stage W-bit delay line with clock enable and synchronous active-high reset.
// Optional feature macro: FF_REG_CLR_EN (synchronous clear via bus.clr).
module ff_reg
    import ff_reg_pkg::*;
#(
    parameter int unsigned  W       = FF_REG_W_DEFAULT,
    parameter int unsigned  DEPTH   = FF_REG_DEPTH_DEFAULT,
    parameter logic [W-1:0] RST_VAL = W'(ff_reg_zero(W))
) (
    input  logic     clk,
    input  logic     reset_,
    ff_reg_if.slave  bus
);

    if (W == 0) begin : g_chk_w
        $fatal(1, "ff_reg: W must be at least 1");
    end
    if (DEPTH == 0) begin : g_chk_depth
        $fatal(1, "ff_reg: DEPTH must be at least 1");
    end

    logic         clr;
    logic [W-1:0] stage_d [DEPTH];
    logic [W-1:0] stage_q [DEPTH];

`ifdef FF_REG_CLR_EN
    assign clr = bus.clr;
`else
    assign clr = 1'b0;
`endif

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        // Stage 0 takes the input; every later stage takes its predecessor.
        if (i == 0) begin : g_head
            assign stage_d[i] = bus.in;
        end else begin : g_body
            assign stage_d[i] = stage_q[i-1];
        end

        ff_stage #(
            .W       (W),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk    (clk),
            .reset_ (reset_),
            .clr    (clr),
            .en     (bus.en),
            .d      (stage_d[i]),
            .q      (stage_q[i])
        );
    end

    // Output comes straight from the last flop; no path from in to out.
    assign bus.out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_ff_reg.sv
// Self-checking bench for ff_reg: four instances (W/DEPTH = 8/1, 4/3, 1/2, 64/2) checked
// every cycle against a queue model, plus directed literal expectations.
// Honours FF_REG_CLR_EN when defined.
module tb_ff_reg;

    logic clk;
    logic reset_;

    int checks = 0;
    int passes = 0;

    ff_reg_if #(.W(8))  bus8  ();
    ff_reg_if #(.W(4))  bus4  ();
    ff_reg_if #(.W(1))  bus1  ();
    ff_reg_if #(.W(64)) bus64 ();

    ff_reg #(.W(8), .DEPTH(1), .RST_VAL(8'hA5)) u_dut8 (
        .clk (clk), .reset_ (reset_), .bus (bus8)
    );
    ff_reg #(.W(4), .DEPTH(3)) u_dut4 (
        .clk (clk), .reset_ (reset_), .bus (bus4)
    );
    ff_reg #(.W(1), .DEPTH(2)) u_dut1 (
        .clk (clk), .reset_ (reset_), .bus (bus1)
    );
    ff_reg #(.W(64), .DEPTH(2), .RST_VAL(64'hDEAD_BEEF_0123_4567)) u_dut64 (
        .clk (clk), .reset_ (reset_), .bus (bus64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each queue holds the last DEPTH accepted values, newest at the front.
    logic [63:0] m8[$];
    logic [63:0] m4[$];
    logic [63:0] m1[$];
    logic [63:0] m64[$];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        logic clr4;
`ifdef FF_REG_CLR_EN
        clr4 = bus4.clr;
`else
        clr4 = 1'b0;
`endif
        if (reset_) begin
            m8 = {64'hA5};
            m4 = {64'h0, 64'h0, 64'h0};
            m1 = {64'h0, 64'h0};
            m64 = {64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (bus8.en) begin
                m8.push_front(64'(bus8.in));
                void'(m8.pop_back());
            end
            if (clr4) begin
                m4 = {64'h0, 64'h0, 64'h0};
            end else if (bus4.en) begin
                m4.push_front(64'(bus4.in));
                void'(m4.pop_back());
            end
            if (bus1.en) begin
                m1.push_front(64'(bus1.in));
                void'(m1.pop_back());
            end
            if (bus64.en) begin
                m64.push_front(bus64.in);
                void'(m64.pop_back());
            end
        end
    end

    // Compare every DUT output against the oldest model entry, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_out8",  64'(bus8.out),  m8[m8.size()-1]);
            check("model_out4",  64'(bus4.out),  m4[m4.size()-1]);
            check("model_out1",  64'(bus1.out),  m1[m1.size()-1]);
            check("model_out64", bus64.out,      m64[m64.size()-1]);
        end
    end

    // One clock, then return on the following falling edge with fresh random side traffic.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        bus1.in  = 1'($urandom);
        bus1.en  = 1'($urandom);
        bus64.in = {$urandom, $urandom};
        bus64.en = 1'($urandom);
    endtask

    initial begin
        reset_   = 1'b1;
        bus8.en  = 1'b1;
        bus8.in  = 8'h3C;
        bus4.en  = 1'b1;
        bus4.in  = 4'hF;
        bus1.en  = 1'b1;
        bus1.in  = 1'b1;
        bus64.en = 1'b1;
        bus64.in = 64'hFFFF_0000_FFFF_0000;
`ifdef FF_REG_CLR_EN
        bus8.clr  = 1'b0;
        bus4.clr  = 1'b0;
        bus1.clr  = 1'b0;
        bus64.clr = 1'b0;
`endif

        // Reset held with en=1 and live data: reset wins.
        repeat (3) begin
            tick();
            check("reset_out8", 64'(bus8.out), 64'hA5);
            check("reset_prio_out4", 64'(bus4.out), 64'h0);
        end
        reset_ = 1'b0;

        // Single-stage latency on DUT8, enable-gap fill on DUT4.
        bus8.in = 8'h01; bus4.in = 4'h1;
        tick();
        check("lat1_out8_01", 64'(bus8.out), 64'h01);
        check("gap_out4_fill1", 64'(bus4.out), 64'h0);
        bus8.in = 8'h02; bus4.in = 4'h2;
        tick();
        check("lat1_out8_02", 64'(bus8.out), 64'h02);
        bus8.in = 8'h03; bus4.in = 4'h3;
        tick();
        check("lat1_out8_03", 64'(bus8.out), 64'h03);
        check("gap_out4_first", 64'(bus4.out), 64'h1);

        // Two-cycle enable gap: DUT4 must hold and ignore its input.
        bus4.en = 1'b0; bus4.in = 4'hE;
        tick();
        check("gap_hold1", 64'(bus4.out), 64'h1);
        tick();
        check("gap_hold2", 64'(bus4.out), 64'h1);
        bus4.en = 1'b1; bus4.in = 4'h4;
        tick();
        check("gap_resume2", 64'(bus4.out), 64'h2);
        bus4.in = 4'h5;
        tick();
        check("gap_resume3", 64'(bus4.out), 64'h3);

        // Stream 7, 8 then reset for one edge: in-flight data must vanish.
        bus4.in = 4'h7;
        tick();
        check("stream_out4_4", 64'(bus4.out), 64'h4);
        bus4.in = 4'h8;
        tick();
        check("stream_out4_5", 64'(bus4.out), 64'h5);
        reset_ = 1'b1;
        tick();
        check("midrst_out4", 64'(bus4.out), 64'h0);
        check("midrst_out8", 64'(bus8.out), 64'hA5);
        reset_ = 1'b0;
        bus4.in = 4'h9;
        tick();
        check("refill_out4_a", 64'(bus4.out), 64'h0);
        bus4.in = 4'hA;
        tick();
        check("refill_out4_b", 64'(bus4.out), 64'h0);
        bus4.in = 4'hB;
        tick();
        check("refill_out4_c", 64'(bus4.out), 64'h9);

`ifdef FF_REG_CLR_EN
        // Clear together with enable: clear wins, pipeline refills from RST_VAL.
        bus4.clr = 1'b1; bus4.in = 4'hF;
        tick();
        check("clr_prio_out4", 64'(bus4.out), 64'h0);
        bus4.clr = 1'b0; bus4.in = 4'hC;
        tick();
        check("clr_refill_a", 64'(bus4.out), 64'h0);
        tick();
        check("clr_refill_b", 64'(bus4.out), 64'h0);
        tick();
        check("clr_refill_c", 64'(bus4.out), 64'hC);
`endif

        // Random traffic on all instances with toggling enables and rare resets.
        for (int n = 0; n < 300; n++) begin
            reset_  = ($urandom_range(0, 49) == 0);
            bus8.en = 1'($urandom);
            bus8.in = 8'($urandom);
            bus4.en = 1'($urandom);
            bus4.in = 4'($urandom);
`ifdef FF_REG_CLR_EN
            bus4.clr = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
